// File: rtl/gpgpu_host_wg_dispatcher_pkg.sv
// Shared types for the host workgroup dispatcher: FSM state encoding.
package gpgpu_host_wg_dispatcher_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StDrain,
    StDone
  } disp_state_e;

endpackage

// File: rtl/gpgpu_disp_fifo.sv
// Synchronous FIFO for queued kernel commands; push ignored when full, pop ignored when empty.
module gpgpu_disp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrInc = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrInc;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrInc;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpgpu_host_wg_dispatcher.sv
// Host-side workgroup dispatcher: queues kernel launches, expands each into sequential
// workgroup requests with an in-flight cap, and tracks completions per kernel.
module gpgpu_host_wg_dispatcher
  import gpgpu_host_wg_dispatcher_pkg::*;
#(
  parameter int unsigned WG_ID_W      = 32,
  parameter int unsigned DESC_W       = 256,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned KQ_DEPTH     = 4,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               kcmd_valid_i,
  output logic               kcmd_ready_o,
  input  logic [WG_ID_W-1:0] kcmd_base_wg_id_i,
  input  logic [CNT_W-1:0]   kcmd_num_wg_i,
  input  logic [DESC_W-1:0]  kcmd_desc_i,
  output logic               host_req_valid_o,
  input  logic               host_req_ready_i,
  output logic [WG_ID_W-1:0] host_req_wg_id_o,
  output logic [DESC_W-1:0]  host_req_desc_o,
  input  logic               host_rsp_valid_i,
  output logic               host_rsp_ready_o,
  input  logic [WG_ID_W-1:0] host_rsp_wg_id_i,
  output logic               kernel_done_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   inflight_o,
  output logic               err_wg_id_o
);

  localparam int unsigned FifoW = WG_ID_W + CNT_W + DESC_W;
  localparam logic [CNT_W-1:0] MaxInflight = CNT_W'(MAX_INFLIGHT);

  disp_state_e        state_q;
  logic [WG_ID_W-1:0] base_q, wg_id_q;
  logic [CNT_W-1:0]   num_q, issued_q, inflight_q, inflight_d, issued_inc;
  logic [DESC_W-1:0]  desc_q;
  logic               req_valid_q, done_q, err_q, live_q;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FifoW-1:0]   fifo_rdata;
  logic               accept, rsp_in, in_window, id_ok, rsp_ok, rsp_bad;
  logic [WG_ID_W-1:0] id_off;

  assign kcmd_ready_o = live_q && !fifo_full;
  assign fifo_push    = kcmd_valid_i && kcmd_ready_o;
  assign fifo_pop     = (state_q == StIdle) && !fifo_empty;

  gpgpu_disp_fifo #(
    .WIDTH(FifoW),
    .DEPTH(KQ_DEPTH)
  ) u_kcmd_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata({kcmd_base_wg_id_i, kcmd_num_wg_i, kcmd_desc_i}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign accept     = req_valid_q && host_req_ready_i;
  assign rsp_in     = host_rsp_valid_i && live_q;
  assign in_window  = (state_q == StIssue) || (state_q == StDrain);
  // Offset arithmetic wraps modulo 2**WG_ID_W, so ranges crossing zero check correctly.
  assign id_off     = host_rsp_wg_id_i - base_q;
  assign id_ok      = id_off < WG_ID_W'(issued_q);
  assign rsp_ok     = rsp_in && in_window && id_ok && (inflight_q != '0);
  assign rsp_bad    = rsp_in && !(in_window && id_ok);
  assign issued_inc = issued_q + CNT_W'(1);

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !rsp_ok) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!accept && rsp_ok) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      num_q       <= '0;
      desc_q      <= '0;
      issued_q    <= '0;
      inflight_q  <= '0;
      wg_id_q     <= '0;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      live_q <= 1'b1;
      done_q <= 1'b0;
      if (rsp_bad) err_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            {base_q, num_q, desc_q} <= fifo_rdata;
            issued_q <= '0;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          if (num_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            req_valid_q <= 1'b1;
            wg_id_q     <= base_q;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          inflight_q <= inflight_d;
          if (accept) begin
            issued_q    <= issued_inc;
            wg_id_q     <= base_q + WG_ID_W'(issued_inc);
            req_valid_q <= (issued_inc != num_q) && (inflight_d < MaxInflight);
            if (issued_inc == num_q) state_q <= StDrain;
          end else if (!req_valid_q && (inflight_d < MaxInflight)) begin
            // Throttled earlier; a completion freed a slot.
            req_valid_q <= 1'b1;
          end
        end
        StDrain: begin
          inflight_q <= inflight_d;
          if (inflight_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign host_req_valid_o = req_valid_q;
  assign host_req_wg_id_o = wg_id_q;
  assign host_req_desc_o  = desc_q;
  assign host_rsp_ready_o = live_q;
  assign kernel_done_o    = done_q;
  assign busy_o           = (state_q != StIdle) || !fifo_empty;
  assign inflight_o       = inflight_q;
  assign err_wg_id_o      = err_q;

endmodule
